uart_tx_fifo: RTL and testbench

//  Byte FIFO that sits upstream of the UART transmit side and absorbs bursts of
//  CPU output ('.' instruction) while the serial line drains at the baud rate.

---
 rtl/uart_tx_fifo.sv | 109 ++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: enqueues on a write strobe and hands
// one byte at a time to the UART, paced by the UART busy flag.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int START_TIMEOUT = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wdata,
  input  logic                  wr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [7:0]            uart_d,
  output logic                  uart_wre,
  input  logic                  uart_bsy,
  output logic [1:0]            fsm_state
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = $clog2(START_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO     = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = (DEPTH_LOG2)'(1);
  localparam logic [TW-1:0]         TCNT_ONE     = TW'(1);
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [TW-1:0]         tcnt;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Write side: a byte is taken on any cycle wr is high and the FIFO is not
  // full (judged on the registered count, so a same-cycle pop does not help).
  // UART side: uart_wre is a one-cycle strobe; the UART acknowledges by
  // raising uart_bsy, and the next byte waits until uart_bsy has fallen.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == CNT_ZERO);
  assign push      = wr && !full;
  assign drop      = wr && full;
  assign pop       = (state == ISSUE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      tcnt     <= '0;
      uart_d   <= 8'h00;
      uart_wre <= 1'b0;
    end else begin
      uart_wre <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !uart_bsy) state <= ISSUE;
        end
        ISSUE: begin
          uart_d   <= mem[rd_ptr];
          uart_wre <= 1'b1;
          rd_ptr   <= rd_ptr + PTR_ONE;
          tcnt     <= '0;
          state    <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_bsy) begin
            state <= WAIT_END;
          end else begin
            // A UART that never goes busy missed the strobe; give up on that byte.
            tcnt <= tcnt + TCNT_ONE;
            if (tcnt == TIMEOUT_LAST) state <= IDLE;
          end
        end
        WAIT_END: begin
          if (!uart_bsy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UART busy model and an
// in-order scoreboard of delivered bytes.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdata;
  logic       wr;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] uart_d;
  logic       uart_wre;
  logic       uart_bsy;
  logic [1:0] fsm_state;

  logic       force_bsy = 1'b0;
  logic       model_bsy = 1'b0;
  logic       model_en  = 1'b1;
  logic       pend      = 1'b0;
  logic       prev_wre  = 1'b0;
  int         bsy_len   = 4;
  int         bsy_left  = 0;

  logic [7:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int wre_pulses = 0;
  int wre_busy   = 0;
  int wre_long   = 0;
  int max_count  = 0;
  int p0;

  assign uart_bsy = force_bsy | model_bsy;

  uart_tx_fifo #(.DEPTH_LOG2(4), .START_TIMEOUT(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .wdata     (wdata),
    .wr        (wr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .uart_d    (uart_d),
    .uart_wre  (uart_wre),
    .uart_bsy  (uart_bsy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART model + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (int'(count) > max_count) max_count = int'(count);
    if (uart_wre) begin
      wre_pulses++;
      if (uart_bsy) wre_busy++;
      if (prev_wre) wre_long++;
      if (exp_q.size() > 0) check("order", 32'(uart_d), 32'(exp_q.pop_front()));
      else                  check("spurious_wre", 32'(uart_wre), 32'd0);
      if (model_en) pend = 1'b1;
    end else if (pend) begin
      pend      = 1'b0;
      model_bsy = 1'b1;
      bsy_left  = bsy_len;
    end else if (model_bsy) begin
      bsy_left--;
      if (bsy_left == 0) model_bsy = 1'b0;
    end
    prev_wre = uart_wre;
  end

  // driver tasks: called and returning at 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit keep);
    wdata = b;
    wr    = 1'b1;
    if (keep) exp_q.push_back(b);
    step();
    wr = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(empty && fsm_state == 2'd0 && !uart_bsy && exp_q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    wdata   = 8'h00;
    ovf_clr = 1'b0;

    // reset state
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_wre", 32'(uart_wre), 32'd0);
    check("rst_d", 32'(uart_d), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    step();
    reset = 1'b0;
    step();

    // single byte, 40-cycle busy
    bsy_len = 40;
    p0 = wre_pulses;
    push_byte(8'h41, 1'b1);
    check("single_count1", 32'(count), 32'd1);
    check("single_empty0", 32'(empty), 32'd0);
    step();
    check("single_state_issue", 32'(fsm_state), 32'd1);
    check("single_wre_early", 32'(uart_wre), 32'd0);
    step();
    check("single_wre", 32'(uart_wre), 32'd1);
    check("single_d", 32'(uart_d), 32'h41);
    check("single_count0", 32'(count), 32'd0);
    step();
    check("single_wre_drop", 32'(uart_wre), 32'd0);
    wait_drain("single_drain", 200);
    check("single_pulses", 32'(wre_pulses - p0), 32'd1);

    // burst of 16 held back, then released
    bsy_len   = 4;
    force_bsy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    check("burst_full", 32'(full), 32'd1);
    check("burst_count", 32'(count), 32'd16);
    p0 = wre_pulses;
    force_bsy = 1'b0;
    wait_drain("burst_drain", 400);
    check("burst_pulses", 32'(wre_pulses - p0), 32'd16);

    // overflow and sticky flag
    force_bsy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(8'hA0 + i), 1'b1);
    push_byte(8'hAA, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b1;
    push_byte(8'hBB, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf), 32'd1);
    check("ovf_count2", 32'(count), 32'd16);

    // asynchronous reset mid-run
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_wre", 32'(uart_wre), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;

    // write dropped while full even with a pop in the same cycle
    for (int i = 0; i < 16; i++) push_byte(8'(8'hD0 + i), 1'b1);
    check("pf_full", 32'(full), 32'd1);
    force_bsy = 1'b0;
    step();
    check("pf_state_issue", 32'(fsm_state), 32'd1);
    push_byte(8'hCC, 1'b0);
    check("pf_count", 32'(count), 32'd15);
    check("pf_ovf", 32'(ovf), 32'd1);
    check("pf_wre", 32'(uart_wre), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    wait_drain("pf_drain", 400);

    // start timeout: UART never goes busy
    model_en = 1'b0;
    push_byte(8'h51, 1'b1);
    push_byte(8'h52, 1'b1);
    check("to_count2", 32'(count), 32'd2);
    check("to_state_issue", 32'(fsm_state), 32'd1);
    step();
    check("to_wre1", 32'(uart_wre), 32'd1);
    check("to_d1", 32'(uart_d), 32'h51);
    check("to_state_ws", 32'(fsm_state), 32'd2);
    repeat (6) step();
    check("to_still_waiting", 32'(fsm_state), 32'd2);
    step();
    check("to_idle", 32'(fsm_state), 32'd0);
    step();
    check("to_reissue", 32'(fsm_state), 32'd1);
    step();
    check("to_wre2", 32'(uart_wre), 32'd1);
    check("to_d2", 32'(uart_d), 32'h52);
    wait_drain("to_drain", 50);
    model_en = 1'b1;

    // interleaved writes and pops across pointer wrap
    bsy_len = 2;
    p0 = wre_pulses;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(8'h60 + i), 1'b1);
      repeat (i % 8) step();
    end
    wait_drain("wrap_drain", 400);
    check("wrap_pulses", 32'(wre_pulses - p0), 32'd40);

    check("max_count", 32'(max_count <= 16), 32'd1);
    check("wre_while_busy", 32'(wre_busy), 32'd0);
    check("wre_one_cycle", 32'(wre_long), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
